// File: rtl/rv32_mc_core_pkg.sv
// Shared constants for the multi-cycle RV32I subset core.
// Opcodes, funct3 codes, FSM states and immediate helpers.
package rv32_consts;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32_mc_core_regfile.sv
// Register file: two async read ports, one sync write port.
// Entry 0 is hardwired to zero; reset clears every entry.
module rv32_regfile #(
    parameter int NREG = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [$clog2(NREG)-1:0]   i_ra,
    input  logic [$clog2(NREG)-1:0]   i_rb,
    output logic [31:0]               o_a,
    output logic [31:0]               o_b,
    input  logic                      i_we,
    input  logic [$clog2(NREG)-1:0]   i_wa,
    input  logic [31:0]               i_wd
);

    logic [31:0] r_x [NREG];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) r_x[i] <= '0;
        end else if (i_we && i_wa != '0) begin
            r_x[i_wa] <= i_wd;
        end
    end

    assign o_a = (i_ra == '0) ? '0 : r_x[i_ra];
    assign o_b = (i_rb == '0) ? '0 : r_x[i_rb];

endmodule

// File: rtl/rv32_mc_core.sv
// Multi-cycle RV32I subset core: OP_IMM, LW, SW over FETCH/EXEC/MEM.
// Instruction and data ports use req/ack so wait states are tolerated.
module rv32_mc_core
    import rv32_consts::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ack_i,
    input  logic [31:0] instr_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic        retire_o,
    output logic        trap_o
);

    localparam int         AW      = $clog2(NREG);
    localparam logic [5:0] LP_NREG = 6'(NREG);

    state_e      r_state;
    logic        r_live;
    logic        r_retire;
    logic        r_we;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_ea;
    logic [31:0] r_sd;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_ea;
    logic [31:0] w_alu;
    logic        w_is_imm;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_rd_ok;
    logic        w_rs1_ok;
    logic        w_rs2_ok;
    logic        w_legal;
    logic        w_rf_we;
    logic [31:0] w_rf_wd;

    assign w_op    = r_ir[6:0];
    assign w_f3    = r_ir[14:12];
    assign w_rd    = r_ir[11:7];
    assign w_rs1   = r_ir[19:15];
    assign w_rs2   = r_ir[24:20];
    assign w_imm_i = sext12(r_ir[31:20]);
    assign w_imm_s = sext12({r_ir[31:25], r_ir[11:7]});

    assign w_is_imm = (w_op == OP_IMM);
    assign w_is_ld  = (w_op == OP_LOAD);
    assign w_is_st  = (w_op == OP_STORE);

    assign w_rd_ok  = ({1'b0, w_rd}  < LP_NREG);
    assign w_rs1_ok = ({1'b0, w_rs1} < LP_NREG);
    assign w_rs2_ok = ({1'b0, w_rs2} < LP_NREG);

    always_comb begin
        w_legal = 1'b0;
        unique case (1'b1)
            w_is_imm: w_legal = (w_f3 != 3'b001) && (w_f3 != 3'b101)
                                && w_rd_ok && w_rs1_ok;
            w_is_ld:  w_legal = (w_f3 == F3_W) && w_rd_ok && w_rs1_ok;
            w_is_st:  w_legal = (w_f3 == F3_W) && w_rs1_ok && w_rs2_ok;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        unique case (w_f3)
            F3_ADD:  w_alu = w_a + w_imm_i;
            F3_SLT:  w_alu = {31'b0, $signed(w_a) < $signed(w_imm_i)};
            F3_SLTU: w_alu = {31'b0, w_a < w_imm_i};
            F3_XOR:  w_alu = w_a ^ w_imm_i;
            F3_OR:   w_alu = w_a | w_imm_i;
            F3_AND:  w_alu = w_a & w_imm_i;
            default: w_alu = '0;
        endcase
    end

    assign w_ea = w_a + (w_is_st ? w_imm_s : w_imm_i);

    assign w_rf_we = ((r_state == ST_EXEC) && w_is_imm && w_legal)
                   || ((r_state == ST_MEM) && mem_ack_i && !r_we);
    assign w_rf_wd = (r_state == ST_MEM) ? mem_data_i : w_alu;

    rv32_regfile #(
        .NREG (NREG)
    ) u_rf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_ra  (w_rs1[AW-1:0]),
        .i_rb  (w_rs2[AW-1:0]),
        .o_a   (w_a),
        .o_b   (w_b),
        .i_we  (w_rf_we),
        .i_wa  (w_rd[AW-1:0]),
        .i_wd  (w_rf_wd)
    );

    // r_live keeps the fetch request low until the first edge after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_FETCH;
            r_live   <= 1'b0;
            r_retire <= 1'b0;
            r_we     <= 1'b0;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_ea     <= '0;
            r_sd     <= '0;
        end else begin
            r_live   <= 1'b1;
            r_retire <= 1'b0;
            unique case (r_state)
                ST_FETCH: begin
                    if (r_live && instr_ack_i) begin
                        r_ir    <= instr_data_i;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!w_legal) begin
                        r_state <= ST_TRAP;
                    end else if (w_is_imm) begin
                        r_pc     <= r_pc + 32'd4;
                        r_retire <= 1'b1;
                        r_state  <= ST_FETCH;
                    end else if (w_ea[1:0] != 2'b00) begin
                        r_state <= ST_TRAP;
                    end else begin
                        r_ea    <= w_ea;
                        r_sd    <= w_b;
                        r_we    <= w_is_st;
                        r_state <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack_i) begin
                        r_pc     <= r_pc + 32'd4;
                        r_retire <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
                end
                default: r_state <= ST_TRAP;
            endcase
        end
    end

    assign instr_req_o  = r_live && (r_state == ST_FETCH);
    assign instr_addr_o = r_pc;
    assign mem_req_o    = (r_state == ST_MEM);
    assign mem_we_o     = mem_req_o && r_we;
    assign mem_addr_o   = r_ea;
    assign mem_data_o   = r_sd;
    assign retire_o     = r_retire;
    assign trap_o       = (r_state == ST_TRAP);

endmodule
